mips_mem_responder: RTL and testbench
=====================================

# mips_mem_responder

Multi-cycle data-memory responder serving the core's load/store requests over a valid/ready handshake. It sits on the memory side of the core's data-memory path. It accepts one request at a time, inserts a programmable number of wait states, performs the word read or byte-enabled write, and holds a response until the core takes it. It flags misaligned or out-of-range accesses instead of touching memory.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words in the array; legal word index 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states between acceptance and memory access; legal 0..255.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i covers bits [8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  core accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  access was misaligned or out of range.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch req_write, req_addr, req_wdata and req_be.
  - If WAIT_CYCLES>0, load an 8-bit counter with WAIT_CYCLES-1 and go to WAIT. Otherwise go to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter is 0, go to RESP on the next edge.
- Access on the edge entering RESP, using the latched fields:
  - err = (addr[1:0]!=0) or (addr[31:2] >= DEPTH).
  - err=1: no memory change; resp_rdata=0; resp_err=1.
  - Store without error: for each i with be[i]=1, write byte i of wdata into mem[addr[31:2]]. be=0000 is a legal no-op store. resp_rdata=0.
  - Load without error: resp_rdata=mem[addr[31:2]]; be is ignored.
- RESP:
  - resp_valid=1, req_ready=0.
  - resp_rdata and resp_err are held stable until resp_ready=1.
  - On resp_valid&&resp_ready, go to IDLE.
- Request inputs are ignored outside IDLE.
- Only one outstanding request is allowed; there is no queueing.

## Timing
- Reset (reset=0 at an edge):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=0, counter=0.
  - req_ready is forced to 0 while reset is low. req_ready=1 in the first cycle after reset is released.
  - Memory array contents are not affected by reset.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- Throughput: the minimum spacing between accepted requests is WAIT_CYCLES+2 cycles. This occurs with resp_ready held at 1: there is one IDLE cycle after each response handshake.
- Response hold: resp_ready low stalls indefinitely in RESP; outputs do not change.
- Reset mid-operation:
  - Reset in WAIT drops the request. A store that has not yet reached the RESP-entry edge never commits.
  - Reset in RESP drops the response. A store that already committed stays committed.
- Simultaneous req_valid during RESP or WAIT is not accepted. The core must hold the request until it sees req_ready.
- Wrap/limits:
  - The counter never underflows; WAIT exits at 0.
  - Addresses at or above DEPTH*4 never alias; they set resp_err.

## Test plan
- Reset:
  - Stimulus: hold reset=0 for 3 cycles with req_valid=1.
  - Response: req_ready=0 and resp_valid=0 throughout. req_ready=1 on the first cycle after release. No request is accepted during reset.
- Store then load, WAIT_CYCLES=2:
  - Stimulus: store 0xDEADBEEF, be=1111, to addr 0x10; then load from addr 0x10.
  - Response: store resp_valid 3 cycles after acceptance with resp_err=0 and rdata=0. Load returns 0xDEADBEEF, also 3 cycles after acceptance.
- Byte enables:
  - Stimulus: after the store above, store 0x11223344 with be=0101 to 0x10, then load 0x10.
  - Response: 0xDE22BE44.
- Errors:
  - Stimulus: load from 0x13; store to DEPTH*4 (0x400 with DEPTH=256); then load 0x10.
  - Response: first two give resp_err=1 and rdata=0. The load of 0x10 still returns the prior value.
- Backpressure and zero wait:
  - Stimulus: WAIT_CYCLES=0; load with resp_ready=0 for 5 cycles, then 1.
  - Response: resp_valid rises 1 cycle after acceptance. rdata and err are stable for all 5 stall cycles. req_ready=0 until the cycle after the handshake.
- Reset mid-WAIT:
  - Stimulus: WAIT_CYCLES=4; store 0xCAFEF00D to 0x20; pulse reset low 2 cycles after acceptance; then load 0x20.
  - Response: no response for the dropped store. The load returns the pre-store contents.

Source files
------------

// File: rtl/mips_mem_responder.sv
// Single-outstanding data-memory responder: accepts one load/store, waits a fixed number
// of cycles, then accesses a word array with byte enables and holds the response until taken.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready for a request; latches it on req_valid && req_ready
// ST_WAIT | counting down wait states; memory access on the exit edge
// ST_RESP | response held stable until resp_ready
module mips_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [DEPTH];

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        err_q;

    logic             accept;
    logic             commit;
    logic             acc_write;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [3:0]       acc_be;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;

    assign accept = req_valid && req_ready;

    // With zero wait states the access happens on the acceptance edge itself,
    // so the request inputs are used directly instead of the latched copy.
    assign commit = (state == ST_IDLE && accept && WAIT_CYCLES == 0) ||
                    (state == ST_WAIT && cnt == 8'd0);

    assign acc_write = (state == ST_IDLE) ? req_write : lat_write;
    assign acc_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
    assign acc_be    = (state == ST_IDLE) ? req_be    : lat_be;
    assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH));
    assign acc_idx   = acc_addr[IDX_W+1:2];

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = reset && (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lat_write <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            cnt       <= 8'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                cnt       <= (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
            end else if (state == ST_WAIT && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
            end
        end
    end

    // The array is never reset; a reset on the commit edge still blocks the store.
    always_ff @(posedge clock) begin
        if (reset && commit && acc_write && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: three instances (2, 0 and 4 wait states) checked every
// cycle against a transaction-level model, plus hand-computed expected values.
module tb_mips_mem_responder;

    logic        clock;
    logic        reset;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        req_valid_a  [3];
    logic        resp_ready_a [3];
    logic        rdy     [3];
    logic        vld     [3];
    logic [31:0] rdata_o [3];
    logic        err_o   [3];

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    mips_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid_a[0]), .req_ready(rdy[0]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld[0]), .resp_ready(resp_ready_a[0]), .resp_rdata(rdata_o[0]),
        .resp_err(err_o[0]));

    mips_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid_a[1]), .req_ready(rdy[1]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld[1]), .resp_ready(resp_ready_a[1]), .resp_rdata(rdata_o[1]),
        .resp_err(err_o[1]));

    mips_mem_responder #(.DEPTH(256), .WAIT_CYCLES(4)) dut2 (
        .clock(clock), .reset(reset), .req_valid(req_valid_a[2]), .req_ready(rdy[2]),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(vld[2]), .resp_ready(resp_ready_a[2]), .resp_rdata(rdata_o[2]),
        .resp_err(err_o[2]));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int wait_of(input int k);
        case (k)
            0: return 2;
            1: return 0;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%h expected=%h", name, k, got, exp);
        end
    endtask

    // Transaction model: a request accepted on edge n is answered on edge n+W.
    int          edge_n = 0;
    int          m_phase [3] = '{0, 0, 0};  // 0 idle, 1 waiting, 2 responding
    int          m_due   [3];
    logic        m_write [3];
    logic [31:0] m_addr  [3];
    logic [31:0] m_wdata [3];
    logic [3:0]  m_be    [3];
    logic        exp_valid [3] = '{0, 0, 0};
    logic [31:0] exp_rdata [3];
    logic        exp_err   [3];
    logic [31:0] mmem [3][256];

    task automatic model_respond(input int k);
        int idx;
        if (m_addr[k] % 4 != 0 || m_addr[k] >= 32'd1024) begin
            exp_err[k]   = 1'b1;
            exp_rdata[k] = 32'd0;
        end else begin
            idx        = int'(m_addr[k] / 4);
            exp_err[k] = 1'b0;
            if (m_write[k]) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[k][b]) mmem[k][idx][8*b +: 8] = m_wdata[k][8*b +: 8];
                exp_rdata[k] = 32'd0;
            end else begin
                exp_rdata[k] = mmem[k][idx];
            end
        end
        exp_valid[k] = 1'b1;
        m_phase[k]   = 2;
    endtask

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset) begin
                m_phase[k]   = 0;
                exp_valid[k] = 1'b0;
            end else begin
                if (m_phase[k] == 2 && resp_ready_a[k]) begin
                    m_phase[k]   = 0;
                    exp_valid[k] = 1'b0;
                end else if (m_phase[k] == 0 && req_valid_a[k]) begin
                    m_write[k] = req_write;
                    m_addr[k]  = req_addr;
                    m_wdata[k] = req_wdata;
                    m_be[k]    = req_be;
                    m_due[k]   = edge_n + wait_of(k);
                    m_phase[k] = 1;
                end
                if (m_phase[k] == 1 && edge_n == m_due[k]) model_respond(k);
            end
        end
        edge_n++;
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chk_en) begin
                for (int k = 0; k < 3; k++) begin
                    chk("req_ready", k, 32'(rdy[k]), 32'(m_phase[k] == 0 && reset));
                    chk("resp_valid", k, 32'(vld[k]), 32'(exp_valid[k]));
                    if (exp_valid[k]) begin
                        chk("resp_rdata", k, rdata_o[k], exp_rdata[k]);
                        chk("resp_err", k, 32'(err_o[k]), 32'(exp_err[k]));
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic txn(input int k, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int stall,
                       output logic [31:0] rd, output logic e);
        bit got;
        int lat;
        rd = 32'hxxxx_xxxx;
        e  = 1'bx;
        req_write       = wr;
        req_addr        = addr;
        req_wdata       = wdata;
        req_be          = be;
        req_valid_a[k]  = 1'b1;
        resp_ready_a[k] = (stall == 0);
        got = 0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clock);
            if (rdy[k]) got = 1;
        end
        if (!got) begin
            chk("accept_timeout", k, 32'd0, 32'd1);
            req_valid_a[k]  = 1'b0;
            resp_ready_a[k] = 1'b1;
            @(posedge clock);
            #1;
            return;
        end
        @(posedge clock);
        #1;
        req_valid_a[k] = 1'b0;
        req_addr       = 32'hFFFF_FFF1;
        req_wdata      = $urandom;
        req_be         = 4'hF;
        req_write      = ~wr;
        got = 0;
        lat = 0;
        while (!got && lat < 300) begin
            @(negedge clock);
            lat++;
            if (vld[k]) got = 1;
        end
        if (!got) begin
            chk("resp_timeout", k, 32'd0, 32'd1);
            resp_ready_a[k] = 1'b1;
            @(posedge clock);
            #1;
            return;
        end
        chk("latency", k, 32'(lat), 32'(wait_of(k) + 1));
        rd = rdata_o[k];
        e  = err_o[k];
        for (int s = 1; s < stall; s++) begin
            @(negedge clock);
            chk("hold_valid", k, 32'(vld[k]), 32'd1);
            chk("hold_rdata", k, rdata_o[k], rd);
            chk("hold_err", k, 32'(err_o[k]), 32'(e));
        end
        resp_ready_a[k] = 1'b1;
        @(posedge clock);
        #1;
    endtask

    logic [31:0] rd;
    logic        e;
    int          seen_valid;

    initial begin
        reset     = 1'b0;
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hFFFF_FFFF;
        req_be    = 4'hF;
        for (int k = 0; k < 3; k++) begin
            req_valid_a[k]  = 1'b1;
            resp_ready_a[k] = 1'b1;
        end
        @(posedge clock);
        #1 chk_en = 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) req_valid_a[k] = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", 0, 32'(rdy[0]), 32'd1);
        @(posedge clock);
        #1;

        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, rd, e);
        chk("store_rdata", 0, rd, 32'd0);
        chk("store_err", 0, 32'(e), 32'd0);
        txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, 0, rd, e);
        chk("load_rdata", 0, rd, 32'hDEAD_BEEF);
        chk("load_err", 0, 32'(e), 32'd0);

        txn(0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, 0, rd, e);
        txn(0, 1'b0, 32'h10, 32'd0, 4'b1111, 0, rd, e);
        chk("be_merge", 0, rd, 32'hDE22_BE44);

        txn(0, 1'b0, 32'h13, 32'd0, 4'b0000, 0, rd, e);
        chk("misalign_err", 0, 32'(e), 32'd1);
        chk("misalign_rdata", 0, rd, 32'd0);
        txn(0, 1'b1, 32'h400, 32'h5555_AAAA, 4'b1111, 0, rd, e);
        chk("range_err", 0, 32'(e), 32'd1);
        chk("range_rdata", 0, rd, 32'd0);
        txn(0, 1'b1, 32'h10, 32'h9999_9999, 4'b0000, 0, rd, e);
        chk("noop_store_err", 0, 32'(e), 32'd0);
        txn(0, 1'b0, 32'h10, 32'd0, 4'b0000, 0, rd, e);
        chk("after_err_rdata", 0, rd, 32'hDE22_BE44);

        txn(0, 1'b1, 32'h3FC, 32'hA5A5_0FF0, 4'b1111, 0, rd, e);
        txn(0, 1'b0, 32'h3FC, 32'd0, 4'b0000, 0, rd, e);
        chk("last_word_rdata", 0, rd, 32'hA5A5_0FF0);
        chk("last_word_err", 0, 32'(e), 32'd0);

        txn(1, 1'b1, 32'h40, 32'h0BAD_F00D, 4'b1111, 0, rd, e);
        txn(1, 1'b0, 32'h40, 32'd0, 4'b0000, 5, rd, e);
        chk("stall_rdata", 1, rd, 32'h0BAD_F00D);
        chk("stall_err", 1, 32'(e), 32'd0);

        txn(2, 1'b1, 32'h20, 32'h1234_5678, 4'b1111, 0, rd, e);
        txn(2, 1'b0, 32'h20, 32'd0, 4'b0000, 0, rd, e);
        chk("pre_store_rdata", 2, rd, 32'h1234_5678);

        req_write      = 1'b1;
        req_addr       = 32'h20;
        req_wdata      = 32'hCAFE_F00D;
        req_be         = 4'hF;
        req_valid_a[2] = 1'b1;
        @(negedge clock);
        chk("midwait_accept", 2, 32'(rdy[2]), 32'd1);
        @(posedge clock);
        #1 req_valid_a[2] = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        seen_valid = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (vld[2]) seen_valid++;
        end
        chk("dropped_resp", 2, 32'(seen_valid), 32'd0);
        @(posedge clock);
        #1;
        txn(2, 1'b0, 32'h20, 32'd0, 4'b0000, 0, rd, e);
        chk("dropped_store_rdata", 2, rd, 32'h1234_5678);

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
